// File: rtl/card_pkg.sv
// Shared constants and FSM state type for the table-map write scheduler.
package card_pkg;

    localparam int CARD_W    = 6;
    localparam int IDX_W     = 8;
    localparam int NUM_SLOTS = 144;
    localparam int SLOT_W    = 6;
    localparam logic [CARD_W-1:0] EMPTY_CARD = 6'd54;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is local, req[1]/gnt[1] is remote.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // 1 = remote was granted last on a contended cycle, so local wins next.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (en && (req == 2'b11)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/map_write_sched.sv
// Owns the table map and select bits; arbitrates local/remote writes and runs the sequenced clear.
// Handshake: a request completes when valid && ready; ready is combinational on valid and is 0 during clear/reset.
module map_write_sched
    import card_pkg::*;
#(
    parameter int                          NUM_SLOTS  = card_pkg::NUM_SLOTS,
    parameter int                          CARD_W     = card_pkg::CARD_W,
    parameter logic [card_pkg::CARD_W-1:0] EMPTY_CARD = card_pkg::EMPTY_CARD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          interboard_rst,
    input  logic                          loc_valid,
    input  logic [IDX_W-1:0]              loc_idx,
    input  logic [CARD_W-1:0]             loc_card,
    input  logic                          loc_sel,
    output logic                          loc_ready,
    input  logic                          rem_valid,
    input  logic [IDX_W-1:0]              rem_idx,
    input  logic [CARD_W-1:0]             rem_card,
    input  logic                          rem_sel,
    output logic                          rem_ready,
    input  logic                          clr_start,
    output logic                          busy,
    output logic                          err_oor,
    output logic [NUM_SLOTS*CARD_W-1:0]   map,
    output logic [NUM_SLOTS-1:0]          sel_card,
    output sched_state_t                  dbg_state
);

    localparam int               OFF_W    = $clog2(NUM_SLOTS * SLOT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W-1:0] SLOTS_I  = IDX_W'(NUM_SLOTS);

    sched_state_t               state_q, state_d;
    logic [IDX_W-1:0]           cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [NUM_SLOTS*CARD_W-1:0] map_q;
    logic [NUM_SLOTS-1:0]       sel_q;

    logic                       rst_any;
    logic                       arb_en;
    logic [1:0]                 gnt;
    logic                       wr_en;
    logic [IDX_W-1:0]           wr_idx;
    logic [CARD_W-1:0]          wr_card;
    logic                       wr_sel;
    logic [OFF_W-1:0]           wr_off;

    assign rst_any = rst | interboard_rst;
    // Clear start and reset both take the port for the cycle, so nobody is granted.
    assign arb_en  = (state_q == ST_IDLE) && !clr_start && !rst_any;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst_any),
        .req ({rem_valid, loc_valid}),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign loc_ready = gnt[0];
    assign rem_ready = gnt[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_card = '0;
        wr_sel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (gnt != 2'b00) begin
                    wr_idx  = gnt[0] ? loc_idx  : rem_idx;
                    wr_card = gnt[0] ? loc_card : rem_card;
                    wr_sel  = gnt[0] ? loc_sel  : rem_sel;
                    wr_en   = (wr_idx < SLOTS_I);
                    err_d   = (wr_idx >= SLOTS_I);
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_card = EMPTY_CARD;
                wr_sel  = 1'b0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_off = OFF_W'(wr_idx) * OFF_W'(SLOT_W);

    always_ff @(posedge clk) begin
        if (rst_any) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            map_q   <= {NUM_SLOTS{EMPTY_CARD}};
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (wr_en) begin
                map_q[wr_off +: CARD_W] <= wr_card;
                sel_q[wr_idx]           <= wr_sel;
            end
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign err_oor   = err_q;
    assign map       = map_q;
    assign sel_card  = sel_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_map_write_sched.sv
// Directed bench for map_write_sched with an acceptance scoreboard and a flat map/sel model.
module tb_map_write_sched;
    import card_pkg::*;

    localparam int MW = NUM_SLOTS * CARD_W;

    logic              clk = 1'b0;
    logic              rst, interboard_rst;
    logic              loc_valid, rem_valid;
    logic [IDX_W-1:0]  loc_idx, rem_idx;
    logic [CARD_W-1:0] loc_card, rem_card;
    logic              loc_sel, rem_sel;
    logic              loc_ready, rem_ready;
    logic              clr_start, busy, err_oor;
    logic [MW-1:0]     map;
    logic [NUM_SLOTS-1:0] sel_card;
    sched_state_t      dbg_state;

    map_write_sched dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .loc_valid(loc_valid), .loc_idx(loc_idx), .loc_card(loc_card),
        .loc_sel(loc_sel), .loc_ready(loc_ready),
        .rem_valid(rem_valid), .rem_idx(rem_idx), .rem_card(rem_card),
        .rem_sel(rem_sel), .rem_ready(rem_ready),
        .clr_start(clr_start), .busy(busy), .err_oor(err_oor),
        .map(map), .sel_card(sel_card), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [14:0]          exp_q[$];
    logic [MW-1:0]        mdl_map;
    logic [NUM_SLOTS-1:0] mdl_sel;
    logic [MW-1:0]        all_empty;
    logic                 s_lr, s_rr, s_busy;

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample readies/busy mid-cycle, then score any acceptance after the edge.
    task automatic tick();
        logic [14:0] e, obs;
        @(negedge clk);
        s_lr   = loc_ready;
        s_rr   = rem_ready;
        s_busy = busy;
        @(posedge clk);
        #1;
        if (s_lr || s_rr) begin
            chk("single_grant", MW'(s_lr && s_rr), '0);
            chk("sb_has_expect", MW'(exp_q.size() == 0), '0);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                obs = s_lr ? {loc_idx, loc_card, loc_sel} : {rem_idx, rem_card, rem_sel};
                chk("grant_item", MW'(obs), MW'(e));
                if (int'(e[14:7]) < NUM_SLOTS) begin
                    mdl_map[int'(e[14:7])*CARD_W +: CARD_W] = e[6:1];
                    mdl_sel[int'(e[14:7])] = e[0];
                end
                chk("map_after_write", map, mdl_map);
                chk("sel_after_write", MW'(sel_card), MW'(mdl_sel));
                chk("err_oor_after_write", MW'(err_oor), MW'(int'(e[14:7]) >= NUM_SLOTS));
            end
        end
    endtask

    task automatic set_loc(input logic v, input int idx, input int card, input logic sel);
        loc_valid = v; loc_idx = IDX_W'(idx); loc_card = CARD_W'(card); loc_sel = sel;
    endtask

    task automatic set_rem(input logic v, input int idx, input int card, input logic sel);
        rem_valid = v; rem_idx = IDX_W'(idx); rem_card = CARD_W'(card); rem_sel = sel;
    endtask

    initial begin
        int zero_rdy, busy_cnt, guard;
        all_empty = {NUM_SLOTS{EMPTY_CARD}};
        rst = 1'b1; interboard_rst = 1'b0; clr_start = 1'b0;
        set_loc(1'b0, 0, 0, 1'b0);
        set_rem(1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mdl_map = all_empty;
        mdl_sel = '0;

        // Reset values
        chk("rst_map", map, all_empty);
        chk("rst_sel", MW'(sel_card), '0);
        chk("rst_busy", MW'(busy), '0);
        chk("rst_err", MW'(err_oor), '0);
        chk("rst_loc_ready", MW'(loc_ready), '0);
        chk("rst_rem_ready", MW'(rem_ready), '0);
        chk("rst_state", MW'(dbg_state), MW'(ST_IDLE));

        // Single local write
        set_loc(1'b1, 5, 14, 1'b1);
        exp_q.push_back({8'd5, 6'd14, 1'b1});
        #1 chk("loc_ready_comb", MW'(loc_ready), 1);
        tick();
        set_loc(1'b0, 0, 0, 1'b0);
        chk("slot5_card", MW'(map[35:30]), 14);
        chk("slot5_sel", MW'(sel_card[5]), 1);
        chk("single_drained", MW'(exp_q.size()), 0);

        // Contention for 4 cycles: expect loc, rem, loc, rem
        set_loc(1'b1, 1, 10, 1'b0);
        set_rem(1'b1, 2, 20, 1'b1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({8'd1, 6'd10, 1'b0});
            exp_q.push_back({8'd2, 6'd20, 1'b1});
        end
        repeat (4) tick();
        set_loc(1'b0, 0, 0, 1'b0);
        set_rem(1'b0, 0, 0, 1'b0);
        chk("contend_drained", MW'(exp_q.size()), 0);
        chk("slot1", MW'(map[11:6]), 10);
        chk("slot2", MW'(map[17:12]), 20);

        // Clear with both requests held
        set_loc(1'b1, 7, 3, 1'b1);
        set_rem(1'b1, 9, 4, 1'b1);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        zero_rdy = (!s_lr && !s_rr) ? 1 : 0;
        busy_cnt = s_busy ? 1 : 0;
        guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            if (loc_ready || rem_ready) break;
            zero_rdy++;
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("clear_timeout", MW'(guard >= 300), '0);
        chk("clear_zero_ready_cycles", MW'(zero_rdy), 145);
        chk("clear_busy_cycles", MW'(busy_cnt), 144);
        chk("clear_map", map, all_empty);
        chk("clear_sel", MW'(sel_card), '0);
        chk("clear_busy_low", MW'(busy), '0);
        chk("clear_loc_first", MW'(loc_ready), 1);
        mdl_map = all_empty;
        mdl_sel = '0;
        @(posedge clk);
        #1;
        exp_q.push_back({8'd7, 6'd3, 1'b1});
        exp_q.push_back({8'd9, 6'd4, 1'b1});
        // The loc acceptance at the edge just passed is scored by hand here.
        mdl_map[7*CARD_W +: CARD_W] = 6'd3;
        mdl_sel[7] = 1'b1;
        void'(exp_q.pop_front());
        chk("held_loc_write", map, mdl_map);
        set_loc(1'b0, 0, 0, 1'b0);
        tick();
        set_rem(1'b0, 0, 0, 1'b0);
        chk("held_drained", MW'(exp_q.size()), 0);

        // Out-of-range remote request
        set_rem(1'b1, 200, 33, 1'b1);
        exp_q.push_back({8'd200, 6'd33, 1'b1});
        tick();
        set_rem(1'b0, 0, 0, 1'b0);
        chk("oor_ready_seen", MW'(s_rr), 1);
        tick();
        chk("oor_pulse_one_cycle", MW'(err_oor), '0);
        chk("oor_map_unchanged", map, mdl_map);

        // interboard_rst aborting a clear at cycle 70
        set_loc(1'b1, 100, 1, 1'b1);
        exp_q.push_back({8'd100, 6'd1, 1'b1});
        tick();
        set_loc(1'b0, 0, 0, 1'b0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (70) tick();
        chk("abort_busy_before", MW'(busy), 1);
        interboard_rst = 1'b1;
        set_loc(1'b1, 143, 52, 1'b0);
        tick();
        interboard_rst = 1'b0;
        chk("abort_no_accept", MW'(s_lr), '0);
        chk("abort_busy", MW'(busy), '0);
        chk("abort_state", MW'(dbg_state), MW'(ST_IDLE));
        chk("abort_map", map, all_empty);
        chk("abort_sel", MW'(sel_card), '0);
        mdl_map = all_empty;
        mdl_sel = '0;
        exp_q.push_back({8'd143, 6'd52, 1'b0});
        tick();
        set_loc(1'b0, 0, 0, 1'b0);
        chk("slot143", MW'(map[863:858]), 52);
        chk("final_drained", MW'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
